// File: rtl/pwm_deadtime_if.sv
// Gate-drive stage bus: PWM/control inputs toward the stage, drive and status back.
interface pwm_deadtime_if #(
    parameter int unsigned DT_W = 8
);
    logic            pwm_in;
    logic            out_en;
    logic [DT_W-1:0] deadtime;
    logic            fault_n;
    logic            fault_clr;
    logic            hs_out;
    logic            ls_out;
    logic            fault;
    logic            dt_active;

    modport master (
        output pwm_in, out_en, deadtime, fault_n, fault_clr,
        input  hs_out, ls_out, fault, dt_active
    );

    modport slave (
        input  pwm_in, out_en, deadtime, fault_n, fault_clr,
        output hs_out, ls_out, fault, dt_active
    );
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary high/low-side drive from one PWM line, with dead time and a
// synchronised, latched fault shutdown. Drives never assert together.
module pwm_deadtime #(
    parameter int unsigned DT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_deadtime_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_DT  = 2'd1,
        ST_HS  = 2'd2,
        ST_LS  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            sync_q1, sync_fault_n;
    logic            fault_q;
    logic            hs_q, ls_q, dt_q;
    logic            run_c;

    assign run_c = bus.out_en & ~fault_q & sync_fault_n;

    // Next state and dead-time counter; loss of run forces OFF from anywhere.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run_c) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d = ST_DT;
                    cnt_d   = bus.deadtime;
                end
                ST_HS: begin
                    if (!bus.pwm_in) begin
                        state_d = ST_DT;
                        cnt_d   = bus.deadtime;
                    end
                end
                ST_LS: begin
                    if (bus.pwm_in) begin
                        state_d = ST_DT;
                        cnt_d   = bus.deadtime;
                    end
                end
                ST_DT: begin
                    if (cnt_q <= DT_W'(1)) begin
                        state_d = bus.pwm_in ? ST_HS : ST_LS;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // State, counter and outputs decoded from the next state so drives come from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            hs_q    <= 1'b0;
            ls_q    <= 1'b0;
            dt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hs_q    <= (state_d == ST_HS);
            ls_q    <= (state_d == ST_LS);
            dt_q    <= (state_d == ST_DT);
        end
    end

    // Two-flop fault synchroniser and latch; a pending fault beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1      <= 1'b1;
            sync_fault_n <= 1'b1;
            fault_q      <= 1'b0;
        end else begin
            sync_q1      <= bus.fault_n;
            sync_fault_n <= sync_q1;
            if (!sync_fault_n) begin
                fault_q <= 1'b1;
            end else if (bus.fault_clr) begin
                fault_q <= 1'b0;
            end
        end
    end

    assign bus.hs_out    = hs_q;
    assign bus.ls_out    = ls_q;
    assign bus.fault     = fault_q;
    assign bus.dt_active = dt_q;
endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed scenarios with literal expectations, then
// randomised stimulus checked every cycle against a behavioural model.
module tb_pwm_deadtime;
    localparam int unsigned DT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    pwm_deadtime_if #(.DT_W(DT_W)) bus ();

    pwm_deadtime #(.DT_W(DT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: dead interval as a remaining-cycle count, drive as two bits.
    int   m_dead = 0;
    logic m_hs = 1'b0, m_ls = 1'b0, m_fault = 1'b0;
    logic m_s1 = 1'b1, m_s2 = 1'b1;
    logic prev_hs = 1'b0, prev_ls = 1'b0;

    initial begin
        logic run, pwm, nf;
        int   d;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_dead = 0; m_hs = 1'b0; m_ls = 1'b0;
                m_fault = 1'b0; m_s1 = 1'b1; m_s2 = 1'b1;
            end else begin
                run = bus.out_en && !m_fault && m_s2;
                pwm = bus.pwm_in;
                d   = int'(bus.deadtime);
                if (!run) begin
                    m_hs = 1'b0; m_ls = 1'b0; m_dead = 0;
                end else if (m_dead > 0) begin
                    m_dead--;
                    if (m_dead == 0) begin
                        m_hs = pwm;
                        m_ls = !pwm;
                    end
                end else if ((m_hs && !pwm) || (m_ls && pwm) || (!m_hs && !m_ls)) begin
                    m_hs = 1'b0; m_ls = 1'b0;
                    m_dead = (d < 1) ? 1 : d;
                end
                nf = !m_s2 ? 1'b1 : (bus.fault_clr ? 1'b0 : m_fault);
                m_s2 = m_s1;
                m_s1 = bus.fault_n;
                m_fault = nf;
            end
            #1;
            chk("model_hs", bus.hs_out, m_hs);
            chk("model_ls", bus.ls_out, m_ls);
            chk("model_fault", bus.fault, m_fault);
            chk("model_dt", bus.dt_active, logic'(m_dead > 0));
            chk("overlap", bus.hs_out & bus.ls_out, 1'b0);
            chk("direct_switch", (prev_hs & bus.ls_out) | (prev_ls & bus.hs_out), 1'b0);
            prev_hs = bus.hs_out;
            prev_ls = bus.ls_out;
        end
    end

    initial begin
        int cnt, bl;
        bit lsseen;
        int pwm_hold, fcnt;
        bus.pwm_in = 1'b0; bus.out_en = 1'b0; bus.deadtime = '0;
        bus.fault_n = 1'b1; bus.fault_clr = 1'b0;
        tick(3);
        chk("rst_hs", bus.hs_out, 1'b0);
        chk("rst_ls", bus.ls_out, 1'b0);
        chk("rst_fault", bus.fault, 1'b0);
        chk("rst_dt", bus.dt_active, 1'b0);
        rst_n = 1'b1;

        // Steady drive: D=4, pwm high
        bus.out_en = 1'b1; bus.deadtime = 8'd4; bus.pwm_in = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (bus.dt_active) cnt++;
        end
        chk_int("steady_dt_cycles", cnt, 4);
        chk("steady_hs", bus.hs_out, 1'b1);
        chk("steady_ls", bus.ls_out, 1'b0);

        // Square wave, D=3
        bus.deadtime = 8'd3; bus.pwm_in = 1'b0;
        tick(1);
        chk("sq_fall_hs", bus.hs_out, 1'b0);
        tick(2);
        chk("sq_fall_ls_wait", bus.ls_out, 1'b0);
        tick(1);
        chk("sq_fall_ls_on", bus.ls_out, 1'b1);
        bus.pwm_in = 1'b1;
        tick(1);
        chk("sq_rise_ls", bus.ls_out, 1'b0);
        tick(2);
        chk("sq_rise_hs_wait", bus.hs_out, 1'b0);
        tick(1);
        chk("sq_rise_hs_on", bus.hs_out, 1'b1);

        // Short low glitch swallowed, D=5
        bus.deadtime = 8'd5; bus.pwm_in = 1'b0;
        cnt = 0; lsseen = 0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            if (i == 1) bus.pwm_in = 1'b1;
            if (bus.dt_active) cnt++;
            if (bus.ls_out) lsseen = 1;
        end
        chk_int("glitch_dt_cycles", cnt, 5);
        chk("glitch_ls_never", logic'(lsseen), 1'b0);
        chk("glitch_back_hs", bus.hs_out, 1'b1);

        // D=0 then D=1: exactly one both-low cycle
        bus.deadtime = 8'd0; bus.pwm_in = 1'b0;
        bl = 0;
        for (int i = 0; i < 10 && !bus.ls_out; i++) begin
            tick(1);
            if (!bus.hs_out && !bus.ls_out) bl++;
        end
        chk("d0_ls_on", bus.ls_out, 1'b1);
        chk_int("d0_bothlow", bl, 1);
        bus.deadtime = 8'd1; bus.pwm_in = 1'b1;
        bl = 0;
        for (int i = 0; i < 10 && !bus.hs_out; i++) begin
            tick(1);
            if (!bus.hs_out && !bus.ls_out) bl++;
        end
        chk("d1_hs_on", bus.hs_out, 1'b1);
        chk_int("d1_bothlow", bl, 1);

        // Fault during HS_ON
        bus.deadtime = 8'd3; bus.fault_n = 1'b0;
        tick(2);
        chk("flt_e1_hs", bus.hs_out, 1'b1);
        chk("flt_e1_fault", bus.fault, 1'b0);
        tick(1);
        chk("flt_e2_fault", bus.fault, 1'b1);
        chk("flt_e2_hs", bus.hs_out, 1'b0);
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        chk("flt_clr_ignored", bus.fault, 1'b1);
        bus.fault_n = 1'b1;
        tick(2);
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        chk("flt_cleared", bus.fault, 1'b0);
        chk("flt_cleared_dt", bus.dt_active, 1'b0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus.dt_active) cnt++;
        end
        chk_int("flt_restart_dt", cnt, 3);
        chk("flt_restart_hs", bus.hs_out, 1'b1);

        // Reset mid-DT, then enable drop during LS_ON
        bus.deadtime = 8'd5; bus.pwm_in = 1'b0;
        tick(2);
        chk("mid_dt_active", bus.dt_active, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dt", bus.dt_active, 1'b0);
        chk("async_rst_hs", bus.hs_out, 1'b0);
        chk("async_rst_ls", bus.ls_out, 1'b0);
        tick(2);
        rst_n = 1'b1;
        bus.deadtime = 8'd2;
        tick(5);
        chk("en_ls_on", bus.ls_out, 1'b1);
        bus.out_en = 1'b0;
        tick(1);
        chk("en_drop_ls", bus.ls_out, 1'b0);
        chk("en_drop_hs", bus.hs_out, 1'b0);
        bus.out_en = 1'b1;

        // Randomised phase, checked by the model process
        pwm_hold = 0; fcnt = 0;
        for (int i = 0; i < 4000; i++) begin
            tick(1);
            if (pwm_hold == 0) begin
                bus.pwm_in = ~bus.pwm_in;
                pwm_hold = $urandom_range(1, 12);
            end else begin
                pwm_hold--;
            end
            if ($urandom_range(0, 7) == 0) bus.deadtime = 8'($urandom_range(0, 7));
            bus.out_en = ($urandom_range(0, 99) != 0);
            if (fcnt > 0) fcnt--;
            else if ($urandom_range(0, 299) == 0) fcnt = $urandom_range(1, 6);
            bus.fault_n = (fcnt == 0);
            bus.fault_clr = ($urandom_range(0, 19) == 0);
        end
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
